// File: rtl/psi_pkg.sv
// Shared types and constants for the psi pulse generator and its regulator.
package psi_pkg;

  localparam int PSI_DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } psi_state_t;

endpackage

// File: rtl/psi_pulse_generator_if.sv
// Control/status bundle between the frequency regulator (master) and the psi generator (slave).
interface psi_pulse_generator_if
  import psi_pkg::*;
#(
  parameter int DIV_W = PSI_DIV_W
) ();

  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             psi;
  logic             period_start;
  logic             busy;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output en,
    output div_in,
    input  psi,
    input  period_start,
    input  busy,
    input  cur_div
  );

  modport slave (
    input  en,
    input  div_in,
    output psi,
    output period_start,
    output busy,
    output cur_div
  );

endinterface

// File: rtl/psi_prescaler.sv
// Free-running clk divider producing a one-cycle tick every PRESCALE cycles; clr restarts it.
module psi_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] pre_cnt_d;

  assign tick = (pre_cnt_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    pre_cnt_d = pre_cnt_q + CNT_W'(1);
    if (clr || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/psi_pulse_generator.sv
// psi pulse train: high phase of (cur_div+1) ticks, fixed low phase, divisor latched per period.
// Optional: define PSI_MIN_DIV_CLAMP_EN to floor the latched divisor at MIN_DIV.
module psi_pulse_generator
  import psi_pkg::*;
#(
  parameter int DIV_W     = PSI_DIV_W,
  parameter int PRESCALE  = 4,
  parameter int LOW_TICKS = 2,
  parameter int MIN_DIV   = 2
) (
  input logic                  clk,
  input logic                  rst,
  psi_pulse_generator_if.slave bus
);

  localparam int TW = DIV_W + 1;

  psi_state_t       state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             psi_q, psi_d;
  logic             period_start_q, period_start_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] div_latch;
  logic             tick;
  logic             clr;

`ifdef PSI_MIN_DIV_CLAMP_EN
  assign div_latch = (bus.div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div_in;
`else
  logic unused_min_div;
  assign unused_min_div = (MIN_DIV != 0);
  assign div_latch      = bus.div_in;
`endif

  psi_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Counters are held at zero while idle so every period starts from a clean tick boundary.
  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = HIGH;
          cur_div_d = div_latch;
        end
      end
      HIGH: begin
        if (tick && (tick_cnt_q == {1'b0, cur_div_q})) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick && (tick_cnt_q == TW'(LOW_TICKS - 1))) begin
          if (bus.en) begin
            state_d   = HIGH;
            cur_div_d = div_latch;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    clr = (state_d != state_q) || (state_q == IDLE);

    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    psi_d          = (state_d == HIGH);
    period_start_d = (state_d == HIGH) && (state_q != HIGH);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      cur_div_q      <= '0;
      psi_q          <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      cur_div_q      <= cur_div_d;
      psi_q          <= psi_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.psi          = psi_q;
  assign bus.period_start = period_start_q;
  assign bus.busy         = busy_q;
  assign bus.cur_div      = cur_div_q;

endmodule

// File: tb/tb_psi_pulse_generator.sv
// Scoreboard bench for psi_pulse_generator: expected pulse lengths queued at stimulus, checked by a monitor.
// Honors PSI_MIN_DIV_CLAMP_EN when computing expected divisors.
module tb_psi_pulse_generator;

  localparam int DIV_W     = 4;
  localparam int PRESCALE  = 4;
  localparam int LOW_TICKS = 2;
  localparam int MIN_DIV   = 2;
  localparam int LOW_LEN   = LOW_TICKS * PRESCALE;

  typedef struct {
    int high_len;
    int low_len;
    int div;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t sb_q[$];
  exp_t cur_rec;
  bit   rec_valid = 1'b0;
  int   mon_phase = 0;
  int   high_cnt = 0;
  int   low_cnt = 0;

  psi_pulse_generator_if #(.DIV_W(DIV_W)) bus ();

  psi_pulse_generator #(
    .DIV_W     (DIV_W),
    .PRESCALE  (PRESCALE),
    .LOW_TICKS (LOW_TICKS),
    .MIN_DIV   (MIN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int expDiv(input int d);
`ifdef PSI_MIN_DIV_CLAMP_EN
    return (d < MIN_DIV) ? MIN_DIV : d;
`else
    return d;
`endif
  endfunction

  function automatic int expHigh(input int d);
    return (expDiv(d) + 1) * PRESCALE;
  endfunction

  task automatic pushPeriod(input int d);
    exp_t r;
    r.high_len = expHigh(d);
    r.low_len  = LOW_LEN;
    r.div      = expDiv(d);
    sb_q.push_back(r);
  endtask

  // Monitor: measures each period's high and low phase and compares with the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      mon_phase = 0;
      rec_valid = 1'b0;
    end else if (bus.period_start) begin
      if (mon_phase == 2 && rec_valid) begin
        checkOutput("low_len", low_cnt, cur_rec.low_len);
      end
      checkOutput("ps_psi", bus.psi, 1);
      checkOutput("sb_has_entry", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        cur_rec   = sb_q.pop_front();
        rec_valid = 1'b1;
        checkOutput("cur_div", bus.cur_div, cur_rec.div);
      end else begin
        rec_valid = 1'b0;
      end
      mon_phase = 1;
      high_cnt  = 1;
    end else if (mon_phase == 1) begin
      if (bus.psi) begin
        high_cnt++;
      end else begin
        if (rec_valid) checkOutput("high_len", high_cnt, cur_rec.high_len);
        mon_phase = 2;
        low_cnt   = bus.busy ? 1 : 0;
      end
    end else if (mon_phase == 2) begin
      if (bus.busy && !bus.psi) begin
        low_cnt++;
      end else begin
        if (rec_valid) checkOutput("low_len", low_cnt, cur_rec.low_len);
        mon_phase = 0;
      end
    end
  end

  task automatic waitPeriodStart();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < 300);
    checkOutput("ps_wait", bus.period_start, 1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_psi", bus.psi, 0);
  endtask

  // Runs back-to-back periods, drops en drop_delay cycles into the last high phase, then waits for idle.
  task automatic applyStimulus(input int d, input int periods, input int drop_delay);
    for (int i = 0; i < periods; i++) pushPeriod(d);
    bus.div_in = DIV_W'(d);
    bus.en     = 1'b1;
    for (int i = 0; i < periods; i++) waitPeriodStart();
    repeat (drop_delay) @(negedge clk);
    bus.en = 1'b0;
    waitIdle();
  endtask

  initial begin
    int ps_cnt;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.div_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_psi", bus.psi, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_period_start", bus.period_start, 0);
    checkOutput("rst_cur_div", bus.cur_div, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] steady train, div=3");
    applyStimulus(3, 3, 0);

    $display("[TB] divisor change mid-period");
    pushPeriod(3);
    pushPeriod(5);
    bus.div_in = DIV_W'(3);
    bus.en     = 1'b1;
    waitPeriodStart();
    repeat (3) @(negedge clk);
    bus.div_in = DIV_W'(5);
    repeat (2) @(negedge clk);
    checkOutput("cur_div_hold", bus.cur_div, 3);
    waitPeriodStart();
    bus.en = 1'b0;
    waitIdle();

    $display("[TB] en dropped at high cycle 5");
    applyStimulus(3, 1, 4);
    ps_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.period_start) ps_cnt++;
    end
    checkOutput("no_more_ps", ps_cnt, 0);
    checkOutput("stay_idle", bus.busy, 0);

    $display("[TB] reset mid-high");
    pushPeriod(3);
    pushPeriod(3);
    bus.div_in = DIV_W'(3);
    bus.en     = 1'b1;
    waitPeriodStart();
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_psi", bus.psi, 0);
    checkOutput("midrst_cur_div", bus.cur_div, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_period_start", bus.period_start, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    waitPeriodStart();
    bus.en = 1'b0;
    waitIdle();

    $display("[TB] div=0");
    applyStimulus(0, 1, 0);

    $display("[TB] div=15, three periods");
    applyStimulus(15, 3, 0);

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    checkOutput("mon_idle", mon_phase, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
